paillier_result_packer: RTL

PAILLIER_RESULT_PACKER -- requirements
Module: paillier_result_packer

---
 rtl/paillier_result_packer_if.sv | 24 ++
 rtl/paillier_result_packer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/paillier_result_packer_if.sv
// Stream bundle for the Paillier result packer: K-bit limb input, W-bit beat output.
// in_valid has no ready (the core cannot stall); a beat transfers on out_valid && out_ready,
// and out_data/out_last stay stable while out_valid is high and out_ready is low.
interface paillier_result_packer_if #(
  parameter int K = 128,
  parameter int W = 32
);
  logic [K-1:0] in_data;
  logic         in_valid;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, out_last
  );
endinterface

// File: rtl/paillier_result_packer.sv
// Collects N K-bit limbs, then streams them as W-bit beats (limb 0, low lane first).
// Optional trailing XOR checksum beat is enabled by macro PAILLIER_PACKER_CHECKSUM_EN.
module paillier_result_packer #(
  parameter int K = 128,
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  paillier_result_packer_if.slave  bus,
  output logic                     busy,
  output logic                     overflow_err,
  output logic [1:0]               fsm_state
);
  localparam int BPL    = K / W;
  localparam int TOTAL  = N * BPL;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int BEAT_W = $clog2(TOTAL + 1);
  localparam int LIDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int LANE_W = (BPL > 1) ? $clog2(BPL) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
`ifdef PAILLIER_PACKER_CHECKSUM_EN
    , CSUM = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [K-1:0]        mem [N];
  logic [CNT_W-1:0]    limb_cnt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [LIDX_W-1:0]   rd_limb;
  logic [LANE_W-1:0]   rd_lane;
  logic [LIDX_W-1:0]   wr_idx;
  logic [W-1:0]        lane_data;
  logic                accept;
  logic                last_data;
  logic                store;
`ifdef PAILLIER_PACKER_CHECKSUM_EN
  logic [W-1:0]        csum_q;
`endif

  assign accept    = bus.out_valid && bus.out_ready;
  assign last_data = (beat_cnt == BEAT_W'(TOTAL - 1));
  assign store     = bus.in_valid && ((state_q == IDLE) || (state_q == FILL));
  assign wr_idx    = (state_q == FILL) ? limb_cnt[LIDX_W-1:0] : '0;
  assign fsm_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    lane_data     = '0;
    for (int j = 0; j < BPL; j++) begin
      if (rd_lane == LANE_W'(j)) lane_data = mem[rd_limb][j*W +: W];
    end
    case (state_q)
      IDLE: begin
        if (bus.in_valid) state_d = (N == 1) ? DRAIN : FILL;
      end
      FILL: begin
        busy = 1'b1;
        if (bus.in_valid && (limb_cnt == CNT_W'(N - 1))) state_d = DRAIN;
      end
      DRAIN: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = lane_data;
`ifdef PAILLIER_PACKER_CHECKSUM_EN
        if (accept && last_data) state_d = CSUM;
`else
        bus.out_last  = last_data;
        if (accept && last_data) state_d = IDLE;
`endif
      end
`ifdef PAILLIER_PACKER_CHECKSUM_EN
      CSUM: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
        bus.out_data  = csum_q;
        if (accept) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Buffer has no reset: its contents are only read after a full fill.
  always_ff @(posedge clk) begin
    if (store) mem[wr_idx] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limb_cnt     <= '0;
      beat_cnt     <= '0;
      rd_limb      <= '0;
      rd_lane      <= '0;
      overflow_err <= 1'b0;
`ifdef PAILLIER_PACKER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      // Any limb arriving outside IDLE/FILL has nowhere to go.
      if (bus.in_valid && !store) overflow_err <= 1'b1;
      case (state_q)
        IDLE: begin
          beat_cnt <= '0;
          rd_limb  <= '0;
          rd_lane  <= '0;
          limb_cnt <= bus.in_valid ? CNT_W'(1) : '0;
`ifdef PAILLIER_PACKER_CHECKSUM_EN
          csum_q   <= '0;
`endif
        end
        FILL: begin
          if (bus.in_valid) limb_cnt <= limb_cnt + 1'b1;
        end
        DRAIN: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
`ifdef PAILLIER_PACKER_CHECKSUM_EN
            csum_q   <= csum_q ^ lane_data;
`endif
            if (rd_lane == LANE_W'(BPL - 1)) begin
              rd_lane <= '0;
              rd_limb <= rd_limb + 1'b1;
            end else begin
              rd_lane <= rd_lane + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
